// File: rtl/bfp_pkg.sv
// Shared constants and types for the BFP group collector.
// No logic here; the types are used by the bank and the top level.
// The backpressure behaviour is defined by the modules that use them.
package bfp_pkg;

  // Default sizes for the collector and the downstream converter.
  localparam int GRPSIZE    = 16;
  localparam int FPEXPSIZE  = 8;
  localparam int FPMANSIZE  = 23;
  localparam int FPWIDTH    = 1 + FPEXPSIZE + FPMANSIZE;
  localparam int BFPEXPSIZE = 8;
  localparam int BFPMANSIZE = 8;

  // Lifecycle of one storage bank.
  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    FILLING = 2'd1,
    FULL    = 2'd2
  } bank_state_e;

  // Number of real elements in a group (1..GRPSIZE), or 0 when idle.
  typedef logic [$clog2(GRPSIZE):0] grp_cnt_t;

  // Returns the biased exponent field of an FP word.
  function automatic logic [FPEXPSIZE-1:0] fp_exp(input logic [FPWIDTH-1:0] w);
    return w[FPWIDTH-2 -: FPEXPSIZE];
  endfunction

endpackage

// File: rtl/bfp_group_bank.sv
// One group bank: element storage, element count, special flag, EMPTY/FILLING/FULL state.
// Latency: a write at edge t is visible after edge t. A close makes the bank FULL after edge t.
// Backpressure: the owner must not write while the bank is FULL. A take empties the bank.
// Ports:
//   clk_i, rst_i                      clock and synchronous active-high reset
//   wr_en_i/wr_close_i/wr_ptr_i       write strobe, group-close flag, slot index
//   wr_exp_i/wr_man_i                 unpacked exponent and {sign, mantissa} fields
//   rd_take_i                         consumer took this (FULL) bank
//   state_o, exps_o, mans_o, count_o, special_o   registered bank contents
module bfp_group_bank
  import bfp_pkg::*;
#(
  parameter int GRPSIZE = 16,
  parameter int EXPW    = 8,
  parameter int MANW    = 24
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       wr_en_i,
  input  logic                       wr_close_i,
  input  logic [$clog2(GRPSIZE)-1:0] wr_ptr_i,
  input  logic [EXPW-1:0]            wr_exp_i,
  input  logic [MANW-1:0]            wr_man_i,
  input  logic                       rd_take_i,
  output bank_state_e                state_o,
  output logic [EXPW-1:0]            exps_o [0:GRPSIZE-1],
  output logic [MANW-1:0]            mans_o [0:GRPSIZE-1],
  output logic [$clog2(GRPSIZE):0]   count_o,
  output logic                       special_o
);

  localparam int CW = $clog2(GRPSIZE) + 1;

  bank_state_e     state_q;
  logic [CW-1:0]   count_q;
  logic            special_q;
  logic [EXPW-1:0] exps_q [0:GRPSIZE-1];
  logic [MANW-1:0] mans_q [0:GRPSIZE-1];

  // Writes are ignored while FULL, so a held group cannot be overwritten.
  wire wr_ok = wr_en_i && (state_q != FULL);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= EMPTY;
      count_q   <= '0;
      special_q <= 1'b0;
    end else begin
      case (state_q)
        EMPTY, FILLING: begin
          if (wr_en_i) begin
            state_q   <= wr_close_i ? FULL : FILLING;
            count_q   <= CW'(wr_ptr_i) + CW'(1);
            // special_q is already clear on entry to EMPTY.
            special_q <= special_q | (&wr_exp_i);
          end
        end
        FULL: begin
          if (rd_take_i) begin
            state_q   <= EMPTY;
            count_q   <= '0;
            special_q <= 1'b0;
          end
        end
        default: state_q <= EMPTY;
      endcase
    end
  end

  // Storage is not reset. Slots at or beyond count_q are masked by the reader.
  always_ff @(posedge clk_i) begin
    if (wr_ok) begin
      exps_q[wr_ptr_i] <= wr_exp_i;
      mans_q[wr_ptr_i] <= wr_man_i;
    end
  end

  assign state_o   = state_q;
  assign exps_o    = exps_q;
  assign mans_o    = mans_q;
  assign count_o   = count_q;
  assign special_o = special_q;

endmodule

// File: rtl/bfp_group_collector.sv
// Collects an FP32 element stream into GRPSIZE groups in ping-pong banks for the BFP converter.
// Latency: 1 cycle from accepting the closing element to o_valid. Throughput is one element per cycle.
// Backpressure: o_ready drops only when the write bank is FULL. It recovers on the cycle after an output transfer.
// Ports:
//   i_clk, i_rst               clock and synchronous active-high reset
//   i_valid/o_ready/i_data     element input handshake; i_last closes the group early
//   o_valid/i_ready            group output handshake
//   o_exps/o_mans              per-slot exponent and {sign, mantissa}; padding slots read zero
//   o_count/o_special          real element count and Inf/NaN flag of the presented group
module bfp_group_collector
  import bfp_pkg::*;
#(
  parameter int GRPSIZE   = bfp_pkg::GRPSIZE,
  parameter int FPEXPSIZE = bfp_pkg::FPEXPSIZE,
  parameter int FPMANSIZE = bfp_pkg::FPMANSIZE
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic                         i_valid,
  output logic                         o_ready,
  input  logic [FPEXPSIZE+FPMANSIZE:0] i_data,
  input  logic                         i_last,
  output logic                         o_valid,
  input  logic                         i_ready,
  output logic [FPEXPSIZE-1:0]         o_exps [0:GRPSIZE-1],
  output logic [FPMANSIZE:0]           o_mans [0:GRPSIZE-1],
  output logic [$clog2(GRPSIZE):0]     o_count,
  output logic                         o_special
);

  localparam int FPWIDTH = 1 + FPEXPSIZE + FPMANSIZE;
  localparam int PW      = $clog2(GRPSIZE);
  localparam int CW      = PW + 1;
  localparam int MANW    = FPMANSIZE + 1;

  logic          wr_sel_q, wr_sel_d;
  logic          rd_sel_q, rd_sel_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;

  bank_state_e    b0_state, b1_state;
  logic [FPEXPSIZE-1:0] b0_exps [0:GRPSIZE-1];
  logic [FPEXPSIZE-1:0] b1_exps [0:GRPSIZE-1];
  logic [MANW-1:0]      b0_mans [0:GRPSIZE-1];
  logic [MANW-1:0]      b1_mans [0:GRPSIZE-1];
  logic [CW-1:0]        b0_count, b1_count, rd_count;
  logic                 b0_special, b1_special;

  bank_state_e wr_state, rd_state;
  logic        wr_fire, rd_fire, wr_close;
  logic [FPEXPSIZE-1:0] in_exp;
  logic [MANW-1:0]      in_man;

  assign wr_state = wr_sel_q ? b1_state : b0_state;
  assign rd_state = rd_sel_q ? b1_state : b0_state;

  // Ready is forced low during reset, before the bank states are known.
  assign o_ready  = !i_rst && (wr_state != FULL);
  assign o_valid  = (rd_state == FULL);
  assign wr_fire  = i_valid && o_ready;
  assign rd_fire  = o_valid && i_ready;
  assign wr_close = i_last || (wr_ptr_q == PW'(GRPSIZE - 1));

  // Raw field split: no hidden-bit insertion and no denormal handling.
  assign in_exp = i_data[FPWIDTH-2 -: FPEXPSIZE];
  assign in_man = {i_data[FPWIDTH-1], i_data[FPMANSIZE-1:0]};

  always_comb begin
    wr_sel_d = wr_sel_q;
    wr_ptr_d = wr_ptr_q;
    rd_sel_d = rd_sel_q;
    if (wr_fire) begin
      if (wr_close) begin
        wr_ptr_d = '0;
        wr_sel_d = ~wr_sel_q;
      end else begin
        wr_ptr_d = wr_ptr_q + PW'(1);
      end
    end
    if (rd_fire) rd_sel_d = ~rd_sel_q;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_sel_q <= 1'b0;
      rd_sel_q <= 1'b0;
      wr_ptr_q <= '0;
    end else begin
      wr_sel_q <= wr_sel_d;
      rd_sel_q <= rd_sel_d;
      wr_ptr_q <= wr_ptr_d;
    end
  end

  bfp_group_bank #(.GRPSIZE(GRPSIZE), .EXPW(FPEXPSIZE), .MANW(MANW)) u_bank0 (
    .clk_i      (i_clk),
    .rst_i      (i_rst),
    .wr_en_i    (wr_fire && !wr_sel_q),
    .wr_close_i (wr_close),
    .wr_ptr_i   (wr_ptr_q),
    .wr_exp_i   (in_exp),
    .wr_man_i   (in_man),
    .rd_take_i  (rd_fire && !rd_sel_q),
    .state_o    (b0_state),
    .exps_o     (b0_exps),
    .mans_o     (b0_mans),
    .count_o    (b0_count),
    .special_o  (b0_special)
  );

  bfp_group_bank #(.GRPSIZE(GRPSIZE), .EXPW(FPEXPSIZE), .MANW(MANW)) u_bank1 (
    .clk_i      (i_clk),
    .rst_i      (i_rst),
    .wr_en_i    (wr_fire && wr_sel_q),
    .wr_close_i (wr_close),
    .wr_ptr_i   (wr_ptr_q),
    .wr_exp_i   (in_exp),
    .wr_man_i   (in_man),
    .rd_take_i  (rd_fire && rd_sel_q),
    .state_o    (b1_state),
    .exps_o     (b1_exps),
    .mans_o     (b1_mans),
    .count_o    (b1_count),
    .special_o  (b1_special)
  );

  assign rd_count  = rd_sel_q ? b1_count : b0_count;
  assign o_count   = rd_count;
  assign o_special = rd_sel_q ? b1_special : b0_special;

  // Padding slots of a short group, and stale storage, are presented as zero.
  always_comb begin
    for (int i = 0; i < GRPSIZE; i++) begin
      o_exps[i] = '0;
      o_mans[i] = '0;
      if (CW'(i) < rd_count) begin
        o_exps[i] = rd_sel_q ? b1_exps[i] : b0_exps[i];
        o_mans[i] = rd_sel_q ? b1_mans[i] : b0_mans[i];
      end
    end
  end

endmodule

// File: tb/tb_bfp_group_collector.sv
module tb_bfp_group_collector;
  import bfp_pkg::*;

  localparam int G = GRPSIZE;

  logic        clk = 1'b0;
  logic        i_rst, i_valid, i_last, i_ready;
  logic        o_ready, o_valid, o_special;
  logic [31:0] i_data;
  logic [7:0]  o_exps [0:G-1];
  logic [23:0] o_mans [0:G-1];
  logic [4:0]  o_count;

  bfp_group_collector dut (
    .i_clk    (clk),
    .i_rst    (i_rst),
    .i_valid  (i_valid),
    .o_ready  (o_ready),
    .i_data   (i_data),
    .i_last   (i_last),
    .o_valid  (o_valid),
    .i_ready  (i_ready),
    .o_exps   (o_exps),
    .o_mans   (o_mans),
    .o_count  (o_count),
    .o_special(o_special)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Model: a group is a list of real elements, zero padded, with count and special flag.
  typedef struct packed {
    logic [G-1:0][7:0]  e;
    logic [G-1:0][23:0] m;
    logic [4:0]         cnt;
    logic               sp;
  } grp_t;

  grp_t        exp_q[$];
  logic [7:0]  pe[$];
  logic [23:0] pm[$];
  int          out_cyc[$];
  int          n_out = 0;
  int          last_acc = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
    end
  endtask

  function automatic void model_accept(input logic [31:0] w, input logic last);
    grp_t g;
    pe.push_back(fp_exp(w));
    pm.push_back({w[31], w[22:0]});
    if (pe.size() == G || last) begin
      g = '0;
      g.cnt = 5'(pe.size());
      for (int i = 0; i < pe.size(); i++) begin
        g.e[i] = pe[i];
        g.m[i] = pm[i];
        if (pe[i] == 8'hFF) g.sp = 1'b1;
      end
      exp_q.push_back(g);
      pe.delete();
      pm.delete();
    end
  endfunction

  // Compare process: every presented group is checked against the model head.
  grp_t h;
  always @(negedge clk) begin
    if (!i_rst && o_valid) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_group: DUT presents count %0d, model holds no group", o_count);
      end else begin
        h = exp_q[0];
        chk("grp_count", 64'(o_count), 64'(h.cnt));
        chk("grp_special", 64'(o_special), 64'(h.sp));
        for (int i = 0; i < G; i++) begin
          chk($sformatf("grp_exp[%0d]", i), 64'(o_exps[i]), 64'(h.e[i]));
          chk($sformatf("grp_man[%0d]", i), 64'(o_mans[i]), 64'(h.m[i]));
        end
        if (i_ready) begin
          void'(exp_q.pop_front());
          n_out++;
          out_cyc.push_back(cyc);
        end
      end
    end
  end

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  // Offers one word from posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send(input logic [31:0] w, input logic last, output int waited);
    bit ok;
    ok = 0;
    waited = 0;
    i_valid = 1'b1;
    i_data  = w;
    i_last  = last;
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      if (o_ready) begin
        model_accept(w, last);
        last_acc = cyc;
        ok = 1;
        sync();
        break;
      end
      waited++;
      sync();
    end
    i_valid = 1'b0;
    i_last  = 1'b0;
    if (!ok) begin
      n_cmp++;
      n_err++;
      $display("FAIL send_timeout: word 0x%0h not accepted within 200 cycles", w);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    n_err++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $fatal(1, "watchdog");
  end

  initial begin
    int w, waits, first, base, held;
    i_rst = 1'b1; i_valid = 1'b0; i_last = 1'b0; i_data = '0; i_ready = 1'b0;

    // Reset state
    repeat (3) sync();
    @(negedge clk);
    chk("rst_valid", 64'(o_valid), 0);
    chk("rst_ready", 64'(o_ready), 0);
    chk("rst_count", 64'(o_count), 0);
    chk("rst_special", 64'(o_special), 0);
    chk("rst_exp0", 64'(o_exps[0]), 0);
    chk("rst_man15", 64'(o_mans[15]), 0);
    sync();
    i_rst = 1'b0;
    @(negedge clk);
    chk("rst_ready_after", 64'(o_ready), 1);
    sync();

    // One full group of 1.0+k ulp words
    i_ready = 1'b1;
    waits = 0;
    for (int k = 0; k < 16; k++) begin
      send(32'h3F800000 + k, 1'b0, w);
      waits += w;
    end
    @(negedge clk);
    chk("t1_valid", 64'(o_valid), 1);
    chk("t1_count", 64'(o_count), 16);
    chk("t1_exp5", 64'(o_exps[5]), 64'h7F);
    chk("t1_man9", 64'(o_mans[9]), 64'h9);
    chk("t1_man0", 64'(o_mans[0]), 64'h0);
    chk("t1_no_stall", 64'(waits), 0);
    sync();
    chk("t1_latency", 64'(out_cyc[out_cyc.size()-1] - last_acc), 1);

    // 48 continuous words: groups 16, 32 and 48 cycles after the first accept
    base = out_cyc.size();
    waits = 0;
    first = 0;
    for (int k = 0; k < 48; k++) begin
      send(32'h40000000 + 32'(k * 4096), 1'b0, w);
      if (k == 0) first = last_acc;
      waits += w;
    end
    repeat (3) sync();
    chk("t3_no_stall", 64'(waits), 0);
    chk("t3_groups", 64'(out_cyc.size() - base), 3);
    if (out_cyc.size() - base == 3)
      for (int j = 0; j < 3; j++)
        chk($sformatf("t3_group%0d_cycle", j), 64'(out_cyc[base+j] - first), 64'(16 * (j + 1)));

    // Backpressure: both banks fill, the 33rd word is held
    i_ready = 1'b0;
    waits = 0;
    for (int k = 0; k < 32; k++) begin
      send((k < 16) ? (32'h40000000 + k) : (32'h40800000 + k), 1'b0, w);
      waits += w;
    end
    @(negedge clk);
    chk("t4_no_stall", 64'(waits), 0);
    chk("t4_ready_low", 64'(o_ready), 0);
    chk("t4_valid", 64'(o_valid), 1);
    sync();
    i_valid = 1'b1;
    i_data  = 32'hC0000000;
    i_last  = 1'b0;
    held = 0;
    repeat (3) begin
      @(negedge clk);
      if (o_ready) held++;
      sync();
    end
    chk("t4_held", 64'(held), 0);
    i_ready = 1'b1;
    @(negedge clk);
    chk("t4_ready_not_comb", 64'(o_ready), 0);
    sync();
    i_ready = 1'b0;
    @(negedge clk);
    chk("t4_ready_next", 64'(o_ready), 1);
    if (o_ready) model_accept(32'hC0000000, 1'b0);
    sync();
    i_valid = 1'b0;

    // Short group: 0xC0000000 first, 5th word carries i_last.
    // 0xC0000000 -> exp 0x80, {sign,man} = 0x800000.
    i_ready = 1'b1;
    send(32'h3F800001, 1'b0, w);
    send(32'h3F800002, 1'b0, w);
    send(32'h3F800003, 1'b0, w);
    send(32'h40400000, 1'b1, w);
    @(negedge clk);
    chk("t5_valid", 64'(o_valid), 1);
    chk("t5_count", 64'(o_count), 5);
    chk("t5_exp0", 64'(o_exps[0]), 64'h80);
    chk("t5_man0", 64'(o_mans[0]), 64'h800000);
    chk("t5_exp5", 64'(o_exps[5]), 0);
    chk("t5_man15", 64'(o_mans[15]), 0);
    chk("t5_special", 64'(o_special), 0);
    sync();

    // Special value in slot 3, then a short clean group
    for (int k = 0; k < 16; k++)
      send((k == 3) ? 32'h7F800000 : (32'h3F800000 + k), 1'b0, w);
    @(negedge clk);
    chk("t6_special", 64'(o_special), 1);
    chk("t6_exp3", 64'(o_exps[3]), 64'hFF);
    sync();
    for (int k = 0; k < 3; k++)
      send(32'h3F000000 + k, (k == 2), w);
    @(negedge clk);
    chk("t6b_special", 64'(o_special), 0);
    chk("t6b_count", 64'(o_count), 3);
    chk("t6b_exp0", 64'(o_exps[0]), 64'h7E);
    sync();

    // Reset after 9 words discards the partial group
    for (int k = 0; k < 9; k++)
      send(32'h42000000 + k, 1'b0, w);
    i_rst = 1'b1;
    pe.delete();
    pm.delete();
    exp_q.delete();
    repeat (2) sync();
    i_rst = 1'b0;
    base = n_out;
    for (int k = 0; k < 16; k++)
      send(32'h41000000 + k, 1'b0, w);
    @(negedge clk);
    chk("t7_count", 64'(o_count), 16);
    chk("t7_exp0", 64'(o_exps[0]), 64'h82);
    chk("t7_man8", 64'(o_mans[8]), 64'h8);
    repeat (4) sync();
    chk("t7_groups", 64'(n_out - base), 1);

    repeat (3) sync();
    chk("end_drained", 64'(exp_q.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
